// File: rtl/sdram_port_arbiter.sv
// Two-requester arbiter in front of one Avalon-MM SDRAM master port; grants whole transactions.
// Optional starvation override for port B is compiled in with `define SDRAM_ARB_STARVE_EN.
module sdram_port_arbiter #(
  parameter int ADDR_W       = 25,
  parameter int DATA_W       = 16,
  parameter int BURST_W      = 4,
  parameter int STARVE_LIMIT = 64
) (
  input  logic                clk_clk,
  input  logic                reset_reset,
  input  logic [ADDR_W-1:0]   a_address,
  input  logic                a_read,
  input  logic                a_write,
  input  logic [DATA_W-1:0]   a_writedata,
  input  logic [DATA_W/8-1:0] a_byteenable,
  input  logic [BURST_W-1:0]  a_burstcount,
  output logic                a_waitrequest,
  output logic [DATA_W-1:0]   a_readdata,
  output logic                a_readdatavalid,
  input  logic [ADDR_W-1:0]   b_address,
  input  logic                b_read,
  input  logic                b_write,
  input  logic [DATA_W-1:0]   b_writedata,
  input  logic [DATA_W/8-1:0] b_byteenable,
  input  logic [BURST_W-1:0]  b_burstcount,
  output logic                b_waitrequest,
  output logic [DATA_W-1:0]   b_readdata,
  output logic                b_readdatavalid,
  output logic [ADDR_W-1:0]   m_address,
  output logic                m_read,
  output logic                m_write,
  output logic [DATA_W-1:0]   m_writedata,
  output logic [DATA_W/8-1:0] m_byteenable,
  output logic [BURST_W-1:0]  m_burstcount,
  input  logic                m_waitrequest,
  input  logic [DATA_W-1:0]   m_readdata,
  input  logic                m_readdatavalid,
  output logic [1:0]          grant_o,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN_A = 2'd1, OWN_B = 2'd2, DRAIN = 2'd3} state_t;

  state_t               state, state_nxt;
  logic                 owner_b, owner_b_nxt;
  logic [BURST_W-1:0]   wr_cnt, wr_cnt_nxt, wr_len, wr_len_nxt, rd_rem, rd_rem_nxt;
  logic [BURST_W-1:0]   bc_eff, len_cur, wr_cnt_inc;
  logic                 a_req, b_req, sel_b, active, wr_accept, rd_accept, starve_win;

  // Handshake: a command transfers on a cycle where m_read/m_write is high and
  // m_waitrequest is low; requesters see the owner's waitrequest, others stall.
  assign a_req     = a_read | a_write;
  assign b_req     = b_read | b_write;
  assign sel_b     = (state == OWN_B);
  assign active    = (state == OWN_A) || (state == OWN_B);
  assign dbg_state = state;

  assign m_address    = sel_b ? b_address    : a_address;
  assign m_writedata  = sel_b ? b_writedata  : a_writedata;
  assign m_byteenable = sel_b ? b_byteenable : a_byteenable;
  assign m_burstcount = sel_b ? b_burstcount : a_burstcount;
  assign m_read       = active & (sel_b ? b_read  : a_read);
  assign m_write      = active & (sel_b ? b_write : a_write);
  assign wr_accept    = m_write & ~m_waitrequest;
  assign rd_accept    = m_read & ~m_write & ~m_waitrequest;

  assign a_waitrequest   = (state == OWN_A) ? m_waitrequest : 1'b1;
  assign b_waitrequest   = (state == OWN_B) ? m_waitrequest : 1'b1;
  assign a_readdata      = m_readdata;
  assign b_readdata      = m_readdata;
  // Beats are routed to the transaction owner only; anything seen in IDLE is dropped.
  assign a_readdatavalid = m_readdatavalid &
                           (((state == DRAIN) & ~owner_b) | ((state == OWN_A) & rd_accept));
  assign b_readdatavalid = m_readdatavalid &
                           (((state == DRAIN) & owner_b) | ((state == OWN_B) & rd_accept));

  always_comb begin
    grant_o = 2'b00;
    case (state)
      OWN_A:   grant_o = 2'b01;
      OWN_B:   grant_o = 2'b10;
      DRAIN:   grant_o = owner_b ? 2'b10 : 2'b01;
      default: grant_o = 2'b00;
    endcase
  end

`ifdef SDRAM_ARB_STARVE_EN
  localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);
  logic [7:0] starve_cnt;

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset)
      starve_cnt <= 8'd0;
    else if (state_nxt == OWN_B && state != OWN_B)
      starve_cnt <= 8'd0;
    else if (b_req && grant_o != 2'b10 && starve_cnt < STARVE_MAX)
      starve_cnt <= starve_cnt + 8'd1;
  end

  assign starve_win = b_req & (starve_cnt >= STARVE_MAX);
`else
  // Strict A priority; the limit only matters when the override is compiled in.
  assign starve_win = (STARVE_LIMIT < 0);
`endif

  always_comb begin
    state_nxt   = state;
    owner_b_nxt = owner_b;
    wr_cnt_nxt  = wr_cnt;
    wr_len_nxt  = wr_len;
    rd_rem_nxt  = rd_rem;
    bc_eff      = (m_burstcount == '0) ? BURST_W'(1) : m_burstcount;
    len_cur     = (wr_cnt == '0) ? bc_eff : wr_len;
    wr_cnt_inc  = wr_cnt + BURST_W'(1);
    case (state)
      IDLE: begin
        wr_cnt_nxt = '0;
        if (starve_win) begin
          state_nxt   = OWN_B;
          owner_b_nxt = 1'b1;
        end else if (a_req) begin
          state_nxt   = OWN_A;
          owner_b_nxt = 1'b0;
        end else if (b_req) begin
          state_nxt   = OWN_B;
          owner_b_nxt = 1'b1;
        end
      end
      OWN_A, OWN_B: begin
        if (wr_accept) begin
          wr_len_nxt = len_cur;
          if (wr_cnt_inc == len_cur) begin
            state_nxt  = IDLE;
            wr_cnt_nxt = '0;
          end else begin
            wr_cnt_nxt = wr_cnt_inc;
          end
        end else if (rd_accept) begin
          // A beat returning in the accept cycle already counts toward the burst.
          if (m_readdatavalid && bc_eff == BURST_W'(1)) begin
            state_nxt  = IDLE;
            rd_rem_nxt = '0;
          end else begin
            state_nxt  = DRAIN;
            rd_rem_nxt = m_readdatavalid ? bc_eff - BURST_W'(1) : bc_eff;
          end
        end
      end
      DRAIN: begin
        if (m_readdatavalid) begin
          rd_rem_nxt = rd_rem - BURST_W'(1);
          if (rd_rem == BURST_W'(1)) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state   <= IDLE;
      owner_b <= 1'b0;
      wr_cnt  <= '0;
      wr_len  <= '0;
      rd_rem  <= '0;
    end else begin
      state   <= state_nxt;
      owner_b <= owner_b_nxt;
      wr_cnt  <= wr_cnt_nxt;
      wr_len  <= wr_len_nxt;
      rd_rem  <= rd_rem_nxt;
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: stimulus pushes expected bus beats into queues,
// a negedge monitor pops and compares every accepted write and every forwarded read beat.
module tb_sdram_port_arbiter;
  localparam int ADDR_W = 25;
  localparam int DATA_W = 16;
  localparam int BURST_W = 4;

  logic                clk = 1'b0;
  logic                reset_reset;
  logic [ADDR_W-1:0]   a_address, b_address, m_address;
  logic                a_read, a_write, b_read, b_write;
  logic [DATA_W-1:0]   a_writedata, b_writedata, m_writedata;
  logic [DATA_W/8-1:0] a_byteenable, b_byteenable, m_byteenable;
  logic [BURST_W-1:0]  a_burstcount, b_burstcount, m_burstcount;
  logic                a_waitrequest, b_waitrequest;
  logic [DATA_W-1:0]   a_readdata, b_readdata, m_readdata;
  logic                a_readdatavalid, b_readdatavalid;
  logic                m_read, m_write, m_waitrequest, m_readdatavalid;
  logic [1:0]          grant_o, dbg_state;

  int checks = 0;
  int failures = 0;
  logic [42:0] wr_q[$];
  logic [17:0] rd_q[$];
  int exp_g[10];
  int n_cyc;
  logic [15:0] d;

  always #5 clk = ~clk;

  sdram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W), .STARVE_LIMIT(4)) dut (
    .clk_clk(clk), .reset_reset(reset_reset),
    .a_address(a_address), .a_read(a_read), .a_write(a_write), .a_writedata(a_writedata),
    .a_byteenable(a_byteenable), .a_burstcount(a_burstcount), .a_waitrequest(a_waitrequest),
    .a_readdata(a_readdata), .a_readdatavalid(a_readdatavalid),
    .b_address(b_address), .b_read(b_read), .b_write(b_write), .b_writedata(b_writedata),
    .b_byteenable(b_byteenable), .b_burstcount(b_burstcount), .b_waitrequest(b_waitrequest),
    .b_readdata(b_readdata), .b_readdatavalid(b_readdatavalid),
    .m_address(m_address), .m_read(m_read), .m_write(m_write), .m_writedata(m_writedata),
    .m_byteenable(m_byteenable), .m_burstcount(m_burstcount), .m_waitrequest(m_waitrequest),
    .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
    .grant_o(grant_o), .dbg_state(dbg_state)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  // Monitor: every accepted write beat and every forwarded read beat must match the queue head.
  always @(negedge clk) begin : monitor
    logic [42:0] wa, we;
    logic [17:0] ra, re;
    if (m_write && !m_waitrequest) begin
      wa = {grant_o, m_address, m_writedata};
      if (wr_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL wr_unexpected actual=%0h required=none @%0t", wa, $time);
      end else begin
        we = wr_q.pop_front();
        check("wr_beat", 64'(wa), 64'(we));
      end
    end
    if (a_readdatavalid || b_readdatavalid) begin
      ra = {a_readdatavalid, b_readdatavalid, a_readdata};
      if (rd_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rd_unexpected actual=%0h required=none @%0t", ra, $time);
      end else begin
        re = rd_q.pop_front();
        check("rd_beat", 64'(ra), 64'(re));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_reset = 1'b1;
    a_address = '0; a_read = 0; a_write = 0; a_writedata = '0; a_byteenable = 2'b11; a_burstcount = '0;
    b_address = '0; b_read = 0; b_write = 0; b_writedata = '0; b_byteenable = 2'b11; b_burstcount = '0;
    m_waitrequest = 1'b0; m_readdata = 16'hFFFF; m_readdatavalid = 1'b1;

    // Reset state, with a stray readdatavalid present
    settle();
    check("rst_grant", grant_o, 2'b00);
    check("rst_a_wait", a_waitrequest, 1'b1);
    check("rst_b_wait", b_waitrequest, 1'b1);
    check("rst_m_cmd", {m_read, m_write}, 2'b00);
    check("rst_rdv", {a_readdatavalid, b_readdatavalid}, 2'b00);
    step(); step();
    reset_reset = 1'b0;
    m_readdatavalid = 1'b0;

    // A read, burst of 4, data back 3 cycles after accept
    step();
    a_address = 25'h100; a_burstcount = 4'd4; a_read = 1'b1;
    settle();
    check("t1_idle_grant", grant_o, 2'b00);
    step(); settle();
    check("t1_grant_a", grant_o, 2'b01);
    check("t1_m_read", m_read, 1'b1);
    check("t1_m_addr", m_address, 25'h100);
    check("t1_m_burst", m_burstcount, 4'd4);
    check("t1_a_wait", a_waitrequest, 1'b0);
    check("t1_b_wait", b_waitrequest, 1'b1);
    step();
    a_read = 1'b0;
    settle();
    check("t1_drain_grant", grant_o, 2'b01);
    check("t1_drain_a_wait", a_waitrequest, 1'b1);
    check("t1_drain_m_read", m_read, 1'b0);
    step(); step();
    for (int i = 0; i < 4; i++) begin
      step();
      d = 16'hD000 + 16'(i);
      rd_q.push_back({2'b10, d});
      m_readdatavalid = 1'b1; m_readdata = d;
      settle();
      check("t1_beat_grant", grant_o, 2'b01);
    end
    step();
    m_readdatavalid = 1'b0;
    settle();
    check("t1_back_idle", grant_o, 2'b00);

    // Simultaneous single writes: A first, one IDLE cycle, then B
    step();
    a_address = 25'h10; a_writedata = 16'hAAAA; a_burstcount = 4'd1; a_write = 1'b1;
    b_address = 25'h20; b_writedata = 16'h5555; b_burstcount = 4'd1; b_write = 1'b1;
    wr_q.push_back({2'b01, 25'h10, 16'hAAAA});
    wr_q.push_back({2'b10, 25'h20, 16'h5555});
    settle();
    check("t2_idle_grant", grant_o, 2'b00);
    step(); settle();
    check("t2_grant_a", grant_o, 2'b01);
    check("t2_wdata_a", m_writedata, 16'hAAAA);
    check("t2_b_wait", b_waitrequest, 1'b1);
    step();
    a_write = 1'b0;
    settle();
    check("t2_turnaround", grant_o, 2'b00);
    step(); settle();
    check("t2_grant_b", grant_o, 2'b10);
    check("t2_wdata_b", m_writedata, 16'h5555);
    check("t2_a_wait", a_waitrequest, 1'b1);
    step();
    b_write = 1'b0;
    settle();
    check("t2_release", grant_o, 2'b00);

    // B 8-beat write burst, waitrequest toggling, A requests mid-burst
    step();
    b_address = 25'h200; b_burstcount = 4'd8; b_writedata = 16'hB000; b_write = 1'b1;
    m_waitrequest = 1'b1;
    settle();
    check("t3_idle_grant", grant_o, 2'b00);
    for (int i = 0; i < 8; i++) begin
      step();
      m_waitrequest = 1'b1;
      b_writedata = 16'hB000 + 16'(i);
      if (i == 2) begin
        a_address = 25'h40; a_burstcount = 4'd1; a_read = 1'b1;
      end
      settle();
      check("t3_hold_grant", grant_o, 2'b10);
      check("t3_a_wait", a_waitrequest, 1'b1);
      step();
      m_waitrequest = 1'b0;
      wr_q.push_back({2'b10, 25'h200, 16'hB000 + 16'(i)});
      settle();
      check("t3_hold_grant_acc", grant_o, 2'b10);
      check("t3_a_wait_acc", a_waitrequest, 1'b1);
    end
    step();
    b_write = 1'b0;
    settle();
    check("t3_release", grant_o, 2'b00);
    step(); settle();
    check("t3_a_after", grant_o, 2'b01);
    step();
    a_read = 1'b0;
    m_readdatavalid = 1'b1; m_readdata = 16'h1234;
    rd_q.push_back({2'b10, 16'h1234});
    settle();
    check("t3_a_drain", grant_o, 2'b01);
    step();
    m_readdatavalid = 1'b0;
    settle();
    check("t3_idle_end", grant_o, 2'b00);

    // Reset during DRAIN with 2 beats outstanding; late beats must be dropped
    step();
    a_address = 25'h300; a_burstcount = 4'd4; a_read = 1'b1;
    step();
    step();
    a_read = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      d = 16'hE000 + 16'(i);
      rd_q.push_back({2'b10, d});
      m_readdatavalid = 1'b1; m_readdata = d;
    end
    step();
    m_readdatavalid = 1'b0;
    reset_reset = 1'b1;
    settle();
    check("t4_rst_grant", grant_o, 2'b00);
    check("t4_rst_state", dbg_state, 2'd0);
    check("t4_rst_a_wait", a_waitrequest, 1'b1);
    step();
    reset_reset = 1'b0;
    m_readdatavalid = 1'b1; m_readdata = 16'hEEEE;
    settle();
    check("t4_late_rdv0", {a_readdatavalid, b_readdatavalid}, 2'b00);
    check("t4_late_grant", grant_o, 2'b00);
    step(); settle();
    check("t4_late_rdv1", {a_readdatavalid, b_readdatavalid}, 2'b00);
    step();
    m_readdatavalid = 1'b0;

    // A reads continuously (single beat returned in accept cycle), B wants one write
`ifdef SDRAM_ARB_STARVE_EN
    exp_g = '{0, 1, 0, 1, 0, 2, 0, 0, 0, 0};
    n_cyc = 6;
`else
    exp_g = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
    n_cyc = 10;
`endif
    step();
    m_waitrequest = 1'b0; m_readdatavalid = 1'b1; m_readdata = 16'hC0DE;
    a_address = 25'h500; a_burstcount = 4'd1; a_read = 1'b1;
    b_address = 25'h600; b_writedata = 16'hBBBB; b_burstcount = 4'd1; b_write = 1'b1;
    for (int k = 0; k < n_cyc; k++) begin
      if (k > 0) step();
      if (exp_g[k] == 1) rd_q.push_back({2'b10, 16'hC0DE});
      if (exp_g[k] == 2) wr_q.push_back({2'b10, 25'h600, 16'hBBBB});
      settle();
      check("t5_grant_seq", grant_o, 2'(exp_g[k]));
    end
    step();
    a_read = 1'b0; b_write = 1'b0; m_readdatavalid = 1'b0;
    settle();
    check("t5_idle_end", grant_o, 2'b00);

    // Read with burstcount 0 behaves as a single beat
    step();
    a_address = 25'h700; a_burstcount = 4'd0; a_read = 1'b1;
    step(); settle();
    check("t6_grant_a", grant_o, 2'b01);
    step();
    a_read = 1'b0;
    m_readdatavalid = 1'b1; m_readdata = 16'h0F0F;
    rd_q.push_back({2'b10, 16'h0F0F});
    settle();
    check("t6_drain", grant_o, 2'b01);
    step();
    m_readdatavalid = 1'b0;
    settle();
    check("t6_single_beat", grant_o, 2'b00);
    check("t6_state_idle", dbg_state, 2'd0);

    step(); step(); step();
    check("wr_q_drained", 64'(wr_q.size()), 64'd0);
    check("rd_q_drained", 64'(rd_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
